// File: rtl/count_uart_tx.sv
// 8N1 UART transmitter for a counter value. It can optionally drop bytes that
// repeat the last byte it transmitted.
module count_uart_tx #(
  parameter int CLK_DIV   = 16,
  parameter int ON_CHANGE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    last_byte;
  logic          last_vld;
  logic          bit_end, xfer, suppress, start_frame;

  always_comb begin
    bit_end     = (bit_cnt == CNT_MAX);
    xfer        = valid && (state == IDLE);
    // A repeat of the last sent byte is consumed but never framed.
    suppress    = (ON_CHANGE != 0) && last_vld && (data == last_byte);
    start_frame = xfer && !suppress;
    state_nxt   = state;
    case (state)
      IDLE:    if (start_frame) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    ready = !busy;
    done  = (state == STOP) && bit_end;
    tx    = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      last_byte <= '0;
      last_vld  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_frame) begin
        shreg     <= data;
        last_byte <= data;
        last_vld  <= 1'b1;
        bit_cnt   <= '0;
        bit_idx   <= '0;
      end else if (busy) begin
        bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
        if (state == DATA && bit_end) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx. Two instances are driven with the same inputs:
// dut0 uses ON_CHANGE=1 and dut1 uses ON_CHANGE=0. Each instance is checked against a frame-position model.
module tb_count_uart_tx;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = 10 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] ready, tx, busy, done;

  int vectors = 0, miscompares = 0;

  count_uart_tx #(.CLK_DIV(CLK_DIV), .ON_CHANGE(1)) dut0 (
    .clk(clk), .rst(rst), .data(data), .valid(valid),
    .ready(ready[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));

  count_uart_tx #(.CLK_DIV(CLK_DIV), .ON_CHANGE(0)) dut1 (
    .clk(clk), .rst(rst), .data(data), .valid(valid),
    .ready(ready[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));

  always #5 clk = ~clk;

  // Model: rem = frame cycles still to go (0 = idle), fb = byte being framed.
  int         rem[2] = '{0, 0};
  logic [7:0] fb[2];
  bit         lv[2] = '{0, 0};
  logic [7:0] lb[2];
  bit         armed = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        rem[i] = 0;
        lv[i]  = 0;
      end else if (rem[i] != 0) begin
        rem[i] = rem[i] - 1;
      end else if (valid) begin
        if (!(i == 0 && lv[i] && data == lb[i])) begin
          lv[i]  = 1;
          lb[i]  = data;
          fb[i]  = data;
          rem[i] = FRAME;
        end
      end
    end
    if (rst) armed = 1;
  end

  task automatic chk(string nm, int i, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d t=%0t got %b want %b", nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int pos;
    logic [9:0] fr;
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        if (rem[i] != 0) begin
          pos = FRAME - rem[i];
          fr  = {1'b1, fb[i], 1'b0};
          chk("tx", i, tx[i], fr[pos / CLK_DIV]);
          chk("done", i, done[i], pos == FRAME - 1);
          chk("busy", i, busy[i], 1'b1);
          chk("ready", i, ready[i], 1'b0);
        end else begin
          chk("tx", i, tx[i], 1'b1);
          chk("done", i, done[i], 1'b0);
          chk("busy", i, busy[i], 1'b0);
          chk("ready", i, ready[i], 1'b1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait();
    int n = 0;
    while ((rem[0] != 0 || rem[1] != 0) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      miscompares++;
      $display("FAIL idle_timeout t=%0t", $time);
    end
  endtask

  task automatic send(logic [7:0] b);
    idle_wait();
    valid = 1'b1;
    data  = b;
    step();
    valid = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_a5;
    exp_a5 = 10'b11_0100_1010;  // stop=1, 0xA5 LSB first, start=0

    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 0, ready[0], 1'b1);
    chk("rst_tx", 0, tx[0], 1'b1);
    chk("rst_done", 0, done[0], 1'b0);
    step();

    // 0xA5 frame pinned against literal bit pattern
    send(8'hA5);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      chk("a5_tx", 0, tx[0], exp_a5[c / CLK_DIV]);
      chk("a5_done", 0, done[0], c == FRAME - 1);
    end
    @(negedge clk);
    chk("a5_ready_after", 0, ready[0], 1'b1);
    step();

    // repeat suppression on dut0 only
    send(8'h03);
    send(8'h03);
    @(negedge clk);
    chk("sup_ready", 0, ready[0], 1'b1);
    chk("sup_tx", 0, tx[0], 1'b1);
    chk("nosup_busy", 1, busy[1], 1'b1);
    step();
    send(8'h04);
    @(negedge clk);
    chk("chg_busy", 0, busy[0], 1'b1);
    step();

    // valid held high, data changing mid-frame
    idle_wait();
    valid = 1'b1;
    data  = 8'h10;
    repeat (6) step();
    data = 8'h11;
    repeat (60) step();
    data = 8'h55;
    repeat (40) step();
    valid = 1'b0;
    idle_wait();

    // reset during data bit 3 of 0x00
    send(8'h00);
    repeat (17) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tx", 0, tx[0], 1'b1);
    chk("abort_ready", 0, ready[0], 1'b1);
    chk("abort_done", 0, done[0], 1'b0);
    step();
    send(8'h00);
    @(negedge clk);
    chk("post_rst_busy", 0, busy[0], 1'b1);
    step();

    // transfer on a reset edge is dropped
    idle_wait();
    rst = 1'b1; valid = 1'b1; data = 8'h66;
    step();
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("rst_xfer_ready", 0, ready[0], 1'b1);
    chk("rst_xfer_busy", 1, busy[1], 1'b0);
    step();

    // 0x7F twice: dut1 sends two frames, dut0 one
    send(8'h7F);
    send(8'h7F);
    @(negedge clk);
    chk("7f_sup0", 0, busy[0], 1'b0);
    chk("7f_send1", 1, busy[1], 1'b1);
    step();

    // valid toggling while busy is ignored
    send(8'h22);
    for (int n = 0; n < 30; n++) begin
      valid = ~valid;
      data  = 8'hFF;
      step();
    end
    valid = 1'b0;
    idle_wait();

    // randomized traffic, small data alphabet to hit suppression
    for (int n = 0; n < 4000; n++) begin
      valid = 1'($urandom_range(0, 1));
      data  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      rst   = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    valid = 1'b0;
    idle_wait();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/count_uart_tx.md
COUNT_UART_TX -- requirements
Module: count_uart_tx

Interface
- REQ-001: Parameter CLK_DIV, default 16: clock cycles per UART bit; legal range 2..65535.
- REQ-002: Parameter ON_CHANGE, default 1: 1 = suppress frames whose byte equals the last transmitted byte; 0 = transmit every accepted byte.
- REQ-003: clk  input  1  sole clock; all state changes on its rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- REQ-005: data  input  8  counter value to transmit (counter q output).
- REQ-006: valid  input  1  data is presented for transfer.
- REQ-007: ready  output  1  block can accept data this cycle.
- REQ-008: tx  output  1  UART serial line, 8N1, idle high.
- REQ-009: busy  output  1  frame in progress (state other than IDLE).
- REQ-010: done  output  1  one-cycle pulse at the end of each transmitted frame.

Function
- REQ-011: The FSM SHALL have states IDLE, START, DATA, STOP.
- REQ-012: ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge where valid && ready.
- REQ-013: data SHALL be captured into an internal shift register at the transfer edge; later changes to data SHALL NOT affect the frame.
- REQ-014: On transfer with a transmitted frame, the FSM SHALL move to START, and tx SHALL be 0 from the cycle following the transfer edge.
- REQ-015: Each bit (start, 8 data, stop) SHALL be held on tx for exactly CLK_DIV cycles, timed by a bit-period counter that restarts at each bit boundary.
- REQ-016: Data bits SHALL be sent LSB first; bit i SHALL be on tx during bit period i+1 of the frame.
- REQ-017: The stop bit SHALL be tx=1 for CLK_DIV cycles.
- REQ-018: A full frame SHALL occupy exactly 10*CLK_DIV cycles from the first start-bit cycle.
- REQ-019: At the last stop-bit cycle, done SHALL be 1 for exactly that cycle; the FSM SHALL be in IDLE with ready=1 on the next cycle.
- REQ-020: With ON_CHANGE=1, a transfer whose byte equals the last transmitted byte (and a byte has been transmitted since reset) SHALL be accepted and discarded: the FSM stays in IDLE, ready stays 1, tx stays 1, done stays 0.
- REQ-021: With ON_CHANGE=1, the first transfer after reset SHALL always be transmitted, regardless of value.
- REQ-022: The last-transmitted byte register SHALL update only when a frame starts, never on a suppressed transfer.
- REQ-023: Back-to-back transfers: with valid held high, the next transfer SHALL occur on the first IDLE cycle after done; the inter-frame gap SHALL be exactly one idle cycle at tx=1.
- REQ-024: valid asserted while busy SHALL be ignored and no data stored; the upstream source must hold valid until it sees ready.
- REQ-025: busy SHALL equal (state != IDLE); ready SHALL equal !busy.

Reset
- REQ-026: While rst=1 at a clock edge, the next state SHALL be: IDLE, tx=1, ready=1, busy=0, done=0; the bit counter, bit index and shift register cleared; the last-transmitted byte marked invalid.
- REQ-027: rst asserted mid-frame SHALL abort the frame; tx SHALL be 1 from the cycle after the reset edge, and no done pulse SHALL be issued for the aborted frame.
- REQ-028: A transfer presented on the same edge as rst=1 SHALL be discarded.

Verification (CLK_DIV=4)
- REQ-029: Reset, then valid=1 with data=0xA5 for one cycle -> tx low 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then high 4 cycles; done pulses at cycle 40 of the frame; ready returns high.
- REQ-030: ON_CHANGE=1: send 0x03, then 0x03 again -> second transfer accepted in 1 cycle with no tx activity and no done; then 0x04 -> full frame.
- REQ-031: valid held high with data stepping 0x10, 0x11 -> two frames separated by exactly one idle cycle; data changed mid-frame does not corrupt the frame in flight.
- REQ-032: rst pulsed during data bit 3 of 0x00 -> tx=1 next cycle, ready=1, no done; next send of 0x00 is transmitted (not suppressed).
- REQ-033: ON_CHANGE=0: send 0x7F twice -> two complete frames, two done pulses.
- REQ-034: valid toggled while busy with data=0xFF -> ignored; only the original byte appears on tx.
